// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: forwarding encodings, flush pattern and operand-select helper
package pipe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_EXM = 2'd1, FWD_MWB = 2'd2} fwd_e;
  localparam logic [1:0] FLUSH_ALL = 2'b11;
  function automatic fwd_e fwd_pick(input logic y0, input logic ld0, input logic y1, input logic rdy1);
    return (y0 && !ld0) ? FWD_EXM : (y1 && rdy1) ? FWD_MWB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decoded ID fields and EX result in, stall/flush/forward controls out
interface pipe_hazard_ctrl_if #(parameter int XLEN = 32, parameter int NUM_REGS = 32, parameter int REG_AW = 5);
  logic i_id_valid;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic i_id_rs1_used;
  logic i_id_rs2_used;
  logic [REG_AW-1:0] i_id_rd;
  logic i_id_wr;
  logic i_id_is_load;
  logic i_ex_br_taken;
  logic i_ext_halt;
  logic o_stall_if;
  logic o_stall_id;
  logic o_bubble_ex;
  logic [1:0] o_flush;
  logic [1:0] o_fwd_rs1;
  logic [1:0] o_fwd_rs2;
  logic [NUM_REGS-1:0] o_busy;
  logic [XLEN-1:0] o_dbg_slots;
  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_id_rd, i_id_wr,
           i_id_is_load, i_ex_br_taken, i_ext_halt,
    input  o_stall_if, o_stall_id, o_bubble_ex, o_flush, o_fwd_rs1, o_fwd_rs2, o_busy, o_dbg_slots
  );
  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_id_rd, i_id_wr,
           i_id_is_load, i_ex_br_taken, i_ext_halt,
    output o_stall_if, o_stall_id, o_bubble_ex, o_flush, o_fwd_rs1, o_fwd_rs2, o_busy, o_dbg_slots
  );
endinterface

// File: rtl/pipe_hazard_ctrl_slot_cmp.sv
// hz_slot_cmp: matches one scoreboard slot against the ID sources; x0 never matches
module hz_slot_cmp #(parameter int REG_AW = 5) (
  input  logic              valid,
  input  logic              wr,
  input  logic              is_load,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              m1,
  output logic              m2,
  output logic              ld_m
);
  assign m1 = valid && wr && rs1_used && (rd == rs1) && (|rs1);
  assign m2 = valid && wr && rs2_used && (rd == rs2) && (|rs2);
  assign ld_m = is_load && (m1 || m2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: EX..WB writer scoreboard driving stall, flush, bubble and forwarding
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int STAGES   = 5,
  parameter int LOAD_LAT = 1
) (
  input logic i_clk,
  input logic i_rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int N = STAGES - 2;
  localparam int SW = REG_AW + 2;
  localparam logic [N-1:0] LL_MASK = N'((1 << LOAD_LAT) - 1);
  logic [N-1:0] s_v, s_wr, s_ld, m1, m2, ldm, y1, y2;
  logic [REG_AW-1:0] s_rd [N];
  logic [NUM_REGS-1:0] busy;
  logic [XLEN-1:0] dbg;
  logic lu, acc, rdy1, quiet;
  for (genvar k = 0; k < N; k++) begin : g_cmp
    hz_slot_cmp #(.REG_AW(REG_AW)) u_cmp (
      .valid(s_v[k]), .wr(s_wr[k]), .is_load(s_ld[k]), .rd(s_rd[k]),
      .rs1(hz.i_id_rs1), .rs2(hz.i_id_rs2),
      .rs1_used(hz.i_id_rs1_used), .rs2_used(hz.i_id_rs2_used),
      .m1(m1[k]), .m2(m2[k]), .ld_m(ldm[k])
    );
  end
  assign lu = hz.i_id_valid && |(ldm & LL_MASK);
  assign acc = hz.i_id_valid && !hz.i_ex_br_taken && !lu;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_v <= '0;
      s_wr <= '0;
      s_ld <= '0;
      for (int k = 0; k < N; k++) s_rd[k] <= '0;
    end else if (!hz.i_ext_halt) begin
      s_v <= {s_v[N-2:0], acc};
      s_wr <= {s_wr[N-2:0], acc && hz.i_id_wr};
      s_ld <= {s_ld[N-2:0], acc && hz.i_id_is_load};
      s_rd[0] <= acc ? hz.i_id_rd : '0;
      for (int k = 1; k < N; k++) s_rd[k] <= s_rd[k-1];
    end
  end
  always_comb begin
    busy = '0;
    dbg = '0;
    for (int k = 0; k < N; k++) begin
      if (s_v[k] && s_wr[k]) busy[s_rd[k]] = 1'b1;
      dbg = dbg | (XLEN'({s_v[k], s_ld[k], s_rd[k]}) << (k * SW));
    end
    busy[0] = 1'b0;
  end
  // isolate the youngest matching slot; anything at slot 2 or older reads the write-through regfile
  assign y1 = m1 & (~m1 + N'(1));
  assign y2 = m2 & (~m2 + N'(1));
  assign rdy1 = !s_ld[1] || (LOAD_LAT <= 1);
  assign quiet = i_rst || !hz.i_id_valid || lu;
  assign hz.o_stall_if = !i_rst && (hz.i_ext_halt || (!hz.i_ex_br_taken && lu));
  assign hz.o_stall_id = hz.o_stall_if;
  assign hz.o_bubble_ex = !i_rst && !hz.i_ext_halt && !hz.i_ex_br_taken && lu;
  assign hz.o_flush = (!i_rst && !hz.i_ext_halt && hz.i_ex_br_taken) ? FLUSH_ALL : 2'b00;
  assign hz.o_fwd_rs1 = quiet ? FWD_RF : fwd_pick(y1[0], s_ld[0], y1[1], rdy1);
  assign hz.o_fwd_rs2 = quiet ? FWD_RF : fwd_pick(y2[0], s_ld[0], y2[1], rdy1);
  assign hz.o_busy = i_rst ? '0 : busy;
  assign hz.o_dbg_slots = i_rst ? '0 : dbg;
endmodule
